spatz_offload_buffer: RTL and testbench

SPATZ_OFFLOAD_BUFFER -- requirements
Module: spatz_offload_buffer

---
 rtl/riscv_pkg.sv | 29 ++
 rtl/spatz_opcode_classify.sv | 33 +++
 rtl/spatz_offload_buffer.sv | 200 ++++++++++++++++++++
 tb/tb_spatz_offload_buffer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared RISC-V definitions used by the Spatz offload path:
//   - instr_t        : raw 32-bit instruction word
//   - OPCODE_*       : major opcodes the vector unit accepts
//   - instr_class_e  : class tag carried with every queued instruction
//   - opcode_of()    : extracts the major opcode field
// -----------------------------------------------------------------------------
package riscv_pkg;

    typedef logic [31:0] instr_t;

    localparam logic [6:0] OPCODE_VEC      = 7'b1010111;
    localparam logic [6:0] OPCODE_LOAD_FP  = 7'b0000111;
    localparam logic [6:0] OPCODE_STORE_FP = 7'b0100111;
    localparam logic [6:0] OPCODE_SYSTEM   = 7'b1110011;

    typedef enum logic [1:0] {
        CLASS_VEC      = 2'd0,
        CLASS_LOAD_FP  = 2'd1,
        CLASS_STORE_FP = 2'd2,
        CLASS_SYSTEM   = 2'd3
    } instr_class_e;

    function automatic logic [6:0] opcode_of(input instr_t instr);
        return instr[6:0];
    endfunction

endpackage

// File: rtl/spatz_opcode_classify.sv
// -----------------------------------------------------------------------------
// spatz_opcode_classify
// Purely combinational decoder of the major opcode into an offload class.
// Ports:
//   instr_i     : instruction word under inspection
//   class_o     : class of the instruction (valid only when supported_o = 1)
//   supported_o : 1 when the opcode is one the vector unit handles
// -----------------------------------------------------------------------------
module spatz_opcode_classify
    import riscv_pkg::*;
(
    input  instr_t       instr_i,
    output instr_class_e class_o,
    output logic         supported_o
);

    // Only the opcode field matters; the rest is deliberately ignored.
    logic unused_instr_bits;
    assign unused_instr_bits = ^instr_i[31:7];

    always_comb begin
        class_o     = CLASS_VEC;
        supported_o = 1'b1;
        case (opcode_of(instr_i))
            OPCODE_VEC:      class_o = CLASS_VEC;
            OPCODE_LOAD_FP:  class_o = CLASS_LOAD_FP;
            OPCODE_STORE_FP: class_o = CLASS_STORE_FP;
            OPCODE_SYSTEM:   class_o = CLASS_SYSTEM;
            default:         supported_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/spatz_offload_buffer.sv
// -----------------------------------------------------------------------------
// spatz_offload_buffer
// FIFO between the scalar core's offload port and the Spatz issue stage.
// Supported instructions are queued with their id and class; unsupported ones
// are accepted, dropped and reported through a one-cycle reject pulse.
//
// Parameters: Depth (1..64, any value, not only powers of two), IdWidth.
// Ports:
//   clk_i, rst_i                     : clock, asynchronous active-high reset
//   flush_i                          : discard every queued entry
//   instr_valid_i/ready_o, instr_i,
//   instr_id_i                       : offload request channel
//   issue_valid_o/ready_i, issue_instr_o,
//   issue_id_o, issue_class_o        : issue channel (registered outputs)
//   reject_valid_o, reject_id_o      : unsupported-opcode notification
//   empty_o, full_o, usage_o         : occupancy status
// Optional build feature:
//   SPATZ_OFFLOAD_STATS_EN adds stat_issued_o / stat_rejected_o, 32-bit
//   wrapping counters of issue handshakes and rejects (not cleared by flush).
// -----------------------------------------------------------------------------
module spatz_offload_buffer
    import riscv_pkg::*;
#(
    parameter int unsigned Depth   = 4,
    parameter int unsigned IdWidth = 5
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic                         instr_valid_i,
    output logic                         instr_ready_o,
    input  logic [31:0]                  instr_i,
    input  logic [IdWidth-1:0]           instr_id_i,
    output logic                         issue_valid_o,
    input  logic                         issue_ready_i,
    output logic [31:0]                  issue_instr_o,
    output logic [IdWidth-1:0]           issue_id_o,
    output logic [1:0]                   issue_class_o,
    output logic                         reject_valid_o,
    output logic [IdWidth-1:0]           reject_id_o,
    output logic                         empty_o,
    output logic                         full_o,
    output logic [$clog2(Depth+1)-1:0]   usage_o
`ifdef SPATZ_OFFLOAD_STATS_EN
    ,
    output logic [31:0]                  stat_issued_o,
    output logic [31:0]                  stat_rejected_o
`endif
);

    localparam int unsigned PtrWidth   = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned UsageWidth = $clog2(Depth + 1);

    // Storage: no reset, written only on push, read into the output stage.
    instr_t             instr_mem [Depth];
    logic [IdWidth-1:0] id_mem    [Depth];
    instr_class_e       class_mem [Depth];

    logic [PtrWidth-1:0]   rd_ptr_reg, wr_ptr_reg;
    logic [PtrWidth-1:0]   rd_ptr_inc, wr_ptr_inc, rd_ptr_next;
    logic [UsageWidth-1:0] usage_reg, usage_after_pop, usage_next;

    logic               issue_valid_reg;
    instr_t             issue_instr_reg, head_instr;
    logic [IdWidth-1:0] issue_id_reg, head_id;
    instr_class_e       issue_class_reg, head_class;

    logic               reject_valid_reg;
    logic [IdWidth-1:0] reject_id_reg;

    instr_class_e in_class;
    logic         in_supported;
    logic         full, system_hold, accept, push, reject, pop;

    spatz_opcode_classify u_classify (
        .instr_i     (instr_i),
        .class_o     (in_class),
        .supported_o (in_supported)
    );

    assign full = (usage_reg == UsageWidth'(Depth));

    // A System instruction acts as a barrier: it waits until everything
    // queued ahead of it has been issued.
    assign system_hold = instr_valid_i && in_supported && (in_class == CLASS_SYSTEM)
                         && (usage_reg != '0);

    // Ready depends only on the current occupancy, never on a same-cycle pop.
    assign instr_ready_o = !full && !flush_i && !system_hold;
    assign accept        = instr_valid_i && instr_ready_o;
    assign push          = accept && in_supported;
    assign reject        = accept && !in_supported;
    assign pop           = issue_valid_reg && issue_ready_i;

    // Explicit wrap so non-power-of-two depths work.
    assign rd_ptr_inc  = (rd_ptr_reg == PtrWidth'(Depth - 1)) ? '0 : rd_ptr_reg + 1'b1;
    assign wr_ptr_inc  = (wr_ptr_reg == PtrWidth'(Depth - 1)) ? '0 : wr_ptr_reg + 1'b1;
    assign rd_ptr_next = pop ? rd_ptr_inc : rd_ptr_reg;

    assign usage_after_pop = pop  ? usage_reg - 1'b1       : usage_reg;
    assign usage_next      = push ? usage_after_pop + 1'b1 : usage_after_pop;

    // Next head of queue for the output register. If the queue is empty once
    // this cycle's pop is done, the head can only be the entry being pushed
    // now (it is not yet in the array); otherwise it already sits in memory.
    always_comb begin
        head_instr = '0;
        head_id    = '0;
        head_class = CLASS_VEC;
        if (usage_after_pop == '0) begin
            if (push) begin
                head_instr = instr_i;
                head_id    = instr_id_i;
                head_class = in_class;
            end
        end else begin
            head_instr = instr_mem[rd_ptr_next];
            head_id    = id_mem[rd_ptr_next];
            head_class = class_mem[rd_ptr_next];
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            instr_mem[wr_ptr_reg] <= instr_i;
            id_mem[wr_ptr_reg]    <= instr_id_i;
            class_mem[wr_ptr_reg] <= in_class;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_reg       <= '0;
            wr_ptr_reg       <= '0;
            usage_reg        <= '0;
            issue_valid_reg  <= 1'b0;
            issue_instr_reg  <= '0;
            issue_id_reg     <= '0;
            issue_class_reg  <= CLASS_VEC;
            reject_valid_reg <= 1'b0;
            reject_id_reg    <= '0;
        end else begin
            // Ready is low during flush, so reject is necessarily 0 then.
            reject_valid_reg <= reject;
            if (reject) begin
                reject_id_reg <= instr_id_i;
            end
            if (flush_i) begin
                rd_ptr_reg      <= '0;
                wr_ptr_reg      <= '0;
                usage_reg       <= '0;
                issue_valid_reg <= 1'b0;
                issue_instr_reg <= '0;
                issue_id_reg    <= '0;
                issue_class_reg <= CLASS_VEC;
            end else begin
                rd_ptr_reg      <= rd_ptr_next;
                wr_ptr_reg      <= push ? wr_ptr_inc : wr_ptr_reg;
                usage_reg       <= usage_next;
                issue_valid_reg <= (usage_next != '0);
                issue_instr_reg <= head_instr;
                issue_id_reg    <= head_id;
                issue_class_reg <= head_class;
            end
        end
    end

    assign issue_valid_o  = issue_valid_reg;
    assign issue_instr_o  = issue_instr_reg;
    assign issue_id_o     = issue_id_reg;
    assign issue_class_o  = issue_class_reg;
    assign reject_valid_o = reject_valid_reg;
    assign reject_id_o    = reject_id_reg;
    assign empty_o        = (usage_reg == '0);
    assign full_o         = full;
    assign usage_o        = usage_reg;

`ifdef SPATZ_OFFLOAD_STATS_EN
    logic [31:0] stat_issued_reg, stat_rejected_reg;

    // Statistics survive flush; only reset clears them.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stat_issued_reg   <= '0;
            stat_rejected_reg <= '0;
        end else begin
            if (pop) begin
                stat_issued_reg <= stat_issued_reg + 32'd1;
            end
            if (reject) begin
                stat_rejected_reg <= stat_rejected_reg + 32'd1;
            end
        end
    end

    assign stat_issued_o   = stat_issued_reg;
    assign stat_rejected_o = stat_rejected_reg;
`endif

endmodule

// File: tb/tb_spatz_offload_buffer.sv
// -----------------------------------------------------------------------------
// tb_spatz_offload_buffer
// Directed bench: a Depth=4 instance for fill/drain, reject, System barrier,
// flush and reset cases, and a Depth=3 instance streaming twelve requests
// through a wrapping queue with an in-order id scoreboard.
// -----------------------------------------------------------------------------
module tb_spatz_offload_buffer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Depth = 4 instance
    logic        flush, in_valid, in_ready, iss_valid, iss_ready, rej_valid, empty, full;
    logic [31:0] instr, iss_instr;
    logic [4:0]  in_id, iss_id, rej_id;
    logic [1:0]  iss_class;
    logic [2:0]  usage;

    // Depth = 3 instance
    logic        flush3, in_valid3, in_ready3, iss_valid3, iss_ready3, rej_valid3, empty3, full3;
    logic [31:0] instr3, iss_instr3;
    logic [4:0]  in_id3, iss_id3, rej_id3;
    logic [1:0]  iss_class3;
    logic [1:0]  usage3;

`ifdef SPATZ_OFFLOAD_STATS_EN
    logic [31:0] st_iss4, st_rej4, st_iss3, st_rej3;
`endif

    spatz_offload_buffer #(.Depth(4), .IdWidth(5)) dut4 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .instr_valid_i(in_valid), .instr_ready_o(in_ready), .instr_i(instr), .instr_id_i(in_id),
        .issue_valid_o(iss_valid), .issue_ready_i(iss_ready), .issue_instr_o(iss_instr),
        .issue_id_o(iss_id), .issue_class_o(iss_class),
        .reject_valid_o(rej_valid), .reject_id_o(rej_id),
        .empty_o(empty), .full_o(full), .usage_o(usage)
`ifdef SPATZ_OFFLOAD_STATS_EN
        , .stat_issued_o(st_iss4), .stat_rejected_o(st_rej4)
`endif
    );

    spatz_offload_buffer #(.Depth(3), .IdWidth(5)) dut3 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush3),
        .instr_valid_i(in_valid3), .instr_ready_o(in_ready3), .instr_i(instr3), .instr_id_i(in_id3),
        .issue_valid_o(iss_valid3), .issue_ready_i(iss_ready3), .issue_instr_o(iss_instr3),
        .issue_id_o(iss_id3), .issue_class_o(iss_class3),
        .reject_valid_o(rej_valid3), .reject_id_o(rej_id3),
        .empty_o(empty3), .full_o(full3), .usage_o(usage3)
`ifdef SPATZ_OFFLOAD_STATS_EN
        , .stat_issued_o(st_iss3), .stat_rejected_o(st_rej3)
`endif
    );

    int tests_run    = 0;
    int tests_failed = 0;

    int   exp_q[$];
    int   rej_q[$];
    int   issued3   = 0;
    int   rejected3 = 0;
    logic cur_sup3  = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            $display("[TB] ok   %-22s = 0x%0h", tag, obs);
        end
    endtask

    // One clock cycle. Mid-cycle it records Depth=3 handshakes into the
    // scoreboard; just after the edge it checks any reject pulse.
    task automatic step();
        #3;
        if (in_valid3 && in_ready3) begin
            if (cur_sup3) exp_q.push_back(int'(in_id3));
            else          rej_q.push_back(int'(in_id3));
        end
        if (iss_valid3 && iss_ready3) begin
            issued3++;
            if (exp_q.size() == 0) check("d3_issue_unexpected", {31'd0, iss_valid3}, 32'd0);
            else                   check("d3_issue_id", {27'd0, iss_id3}, exp_q.pop_front());
        end
        @(posedge clk);
        #1;
        if (rej_valid3) begin
            rejected3++;
            if (rej_q.size() == 0) check("d3_reject_unexpected", {31'd0, rej_valid3}, 32'd0);
            else                   check("d3_reject_id", {27'd0, rej_id3}, rej_q.pop_front());
        end
    endtask

    task automatic push4(input int id);
        in_valid = 1'b1;
        instr    = 32'h57 | (id << 7);
        in_id    = id[4:0];
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        flush = 0; in_valid = 0; instr = '0; in_id = '0; iss_ready = 0;
        flush3 = 0; in_valid3 = 0; instr3 = '0; in_id3 = '0; iss_ready3 = 0;

        // Asynchronous reset takes effect before any clock edge.
        #1 rst = 1'b1;
        #1;
        check("rst_issue_valid", {31'd0, iss_valid}, 32'd0);
        check("rst_reject_valid", {31'd0, rej_valid}, 32'd0);
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_usage", {29'd0, usage}, 32'd0);
        check("rst_issue_instr", iss_instr, 32'd0);
        check("rst_issue_id", {27'd0, iss_id}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("ready_after_reset", {31'd0, in_ready}, 32'd1);

        // Fill Depth=4 with Vec ids 1..4 while the issue side stalls.
        for (int i = 1; i <= 4; i++) begin
            push4(i);
            if (i == 1) begin
                check("latency_valid", {31'd0, iss_valid}, 32'd1);
                check("latency_id", {27'd0, iss_id}, 32'd1);
            end
        end
        in_valid = 1'b1; instr = 32'h57 | (5 << 7); in_id = 5'd5;
        #1;
        check("fill_full", {31'd0, full}, 32'd1);
        check("fill_usage", {29'd0, usage}, 32'd4);
        check("fill_ready_low", {31'd0, in_ready}, 32'd0);
        step();
        in_valid = 1'b0;
        check("full_no_push", {29'd0, usage}, 32'd4);

        // Drain in FIFO order.
        iss_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check("drain_valid", {31'd0, iss_valid}, 32'd1);
            check("drain_id", {27'd0, iss_id}, k);
            check("drain_class", {30'd0, iss_class}, 32'd0);
            check("drain_instr", iss_instr, 32'h57 | (k << 7));
            step();
        end
        iss_ready = 1'b0;
        check("drain_empty", {31'd0, empty}, 32'd1);
        check("drain_issue_valid", {31'd0, iss_valid}, 32'd0);

        // Unsupported opcode with one entry queued.
        push4(9);
        in_valid = 1'b1; instr = 32'h0000_0013; in_id = 5'd7;
        #1;
        check("reject_ready", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        check("reject_pulse", {31'd0, rej_valid}, 32'd1);
        check("reject_id", {27'd0, rej_id}, 32'd7);
        check("reject_usage", {29'd0, usage}, 32'd1);
        step();
        check("reject_one_cycle", {31'd0, rej_valid}, 32'd0);
        check("reject_usage_after", {29'd0, usage}, 32'd1);

        // System barrier at usage 2.
        push4(10);
        check("sys_usage2", {29'd0, usage}, 32'd2);
        in_valid = 1'b1; instr = 32'h0000_2573; in_id = 5'd11;
        #1;
        check("sys_hold_u2", {31'd0, in_ready}, 32'd0);
        step();
        check("sys_usage_hold", {29'd0, usage}, 32'd2);
        iss_ready = 1'b1;
        #1;
        check("sys_hold_pop1", {31'd0, in_ready}, 32'd0);
        check("sys_issue_first", {27'd0, iss_id}, 32'd9);
        step();
        check("sys_issue_second", {27'd0, iss_id}, 32'd10);
        check("sys_hold_u1", {31'd0, in_ready}, 32'd0);
        step();
        check("sys_ready_empty", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0; iss_ready = 1'b0;
        check("sys_issue_valid", {31'd0, iss_valid}, 32'd1);
        check("sys_issue_id", {27'd0, iss_id}, 32'd11);
        check("sys_issue_class", {30'd0, iss_class}, 32'd3);
        check("sys_issue_instr", iss_instr, 32'h0000_2573);
        check("sys_usage", {29'd0, usage}, 32'd1);

        // Flush at usage 3 together with a push.
        push4(12);
        push4(13);
        check("pre_flush_usage", {29'd0, usage}, 32'd3);
        flush = 1'b1; in_valid = 1'b1; instr = 32'h57 | (14 << 7); in_id = 5'd14;
        #1;
        check("flush_ready_low", {31'd0, in_ready}, 32'd0);
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_usage", {29'd0, usage}, 32'd0);
        check("flush_issue_valid", {31'd0, iss_valid}, 32'd0);
        check("flush_empty", {31'd0, empty}, 32'd1);
        push4(15);
        check("post_flush_head", {27'd0, iss_id}, 32'd15);
        check("post_flush_usage", {29'd0, usage}, 32'd1);

        // Simultaneous push and pop with one entry queued.
        iss_ready = 1'b1;
        push4(16);
        iss_ready = 1'b0;
        check("pushpop_usage", {29'd0, usage}, 32'd1);
        check("pushpop_head", {27'd0, iss_id}, 32'd16);

        // Reset in the middle of operation with a reject pulse pending.
        push4(17);
        in_valid = 1'b1; instr = 32'h0000_0013; in_id = 5'd18;
        step();
        in_valid = 1'b0;
        check("midrst_pending", {31'd0, rej_valid}, 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_reject", {31'd0, rej_valid}, 32'd0);
        check("midrst_usage", {29'd0, usage}, 32'd0);
        check("midrst_issue_valid", {31'd0, iss_valid}, 32'd0);
        check("midrst_issue_id", {27'd0, iss_id}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("midrst_ready", {31'd0, in_ready}, 32'd1);

        // Depth=3 stream: ids 1..12, ids 5 and 9 are unsupported (OP-IMM).
        for (int n = 1; n <= 12; n++) begin
            cur_sup3  = !(n == 5 || n == 9);
            in_valid3 = 1'b1;
            instr3    = cur_sup3 ? (32'h57 | (n << 7)) : 32'h0000_0013;
            in_id3    = n[4:0];
            if (n == 4) begin
                #1;
                check("d3_full", {31'd0, full3}, 32'd1);
                check("d3_usage", {30'd0, usage3}, 32'd3);
                check("d3_ready_low", {31'd0, in_ready3}, 32'd0);
                iss_ready3 = 1'b1;
            end
            #1;
            w = 0;
            while (!in_ready3 && w < 20) begin
                step();
                w++;
            end
            if (!in_ready3) check("d3_wait_ready", {31'd0, in_ready3}, 32'd1);
            step();
        end
        in_valid3 = 1'b0;
        w = 0;
        while (!empty3 && w < 20) begin
            step();
            w++;
        end
        check("d3_empty", {31'd0, empty3}, 32'd1);
        check("d3_issued", issued3, 32'd10);
        check("d3_rejected", rejected3, 32'd2);
        check("d3_scoreboard_left", exp_q.size(), 32'd0);
`ifdef SPATZ_OFFLOAD_STATS_EN
        check("d3_stat_issued", st_iss3, 32'd10);
        check("d3_stat_rejected", st_rej3, 32'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
